// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampling, 3-sample majority vote, runtime frame format,
// buffered through a small FIFO with per-character error flags and sticky overrun.
module uart_rx_fifo #(
    parameter int unsigned MAX_DATA_BITS = 9,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned DIV_W         = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_rx_serial,
    input  logic [DIV_W-1:0]         i_baud_div,
    input  logic [3:0]               i_data_bits,
    input  logic [1:0]               i_parity_mode,
    input  logic                     i_stop_bits,
    output logic [MAX_DATA_BITS-1:0] o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_parity_err,
    output logic                     o_frame_err,
    output logic                     o_break,
    output logic                     o_overrun,
    input  logic                     i_clear_err
);

    localparam int unsigned DW = MAX_DATA_BITS;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK_WAIT
    } state_e;

    typedef struct packed {
        logic          brk;
        logic          ferr;
        logic          perr;
        logic [DW-1:0] data;
    } entry_t;

    state_e            state_q;
    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic [DIV_W-1:0]  tick_cnt_q;
    logic [3:0]        os_q;
    logic              s7_q, s8_q;
    logic [3:0]        bit_cnt_q;
    logic [3:0]        nbits_q;
    logic [1:0]        pmode_q;
    logic              stop2_q;
    logic              stop_cnt_q;
    logic [DW-1:0]     data_q;
    logic              perr_q, ferr_q, zero_q, fstop0_q;
    logic [3:0]        hi_cnt_q;

    logic [DIV_W-1:0]  div_eff_c;
    logic [3:0]        nbits_c;
    logic              tick_c, bit_done_c, maj_c, start_edge_c, par_en_c;
    logic              last_stop_c, push_c, brk_c;
    entry_t            push_entry_c;

    // Frame-level decode shared by the FSM and the FIFO write port
    always_comb begin
        div_eff_c    = (i_baud_div == '0) ? DIV_W'(1) : i_baud_div;
        if (i_data_bits < 4'd5)                     nbits_c = 4'd5;
        else if (i_data_bits > 4'(MAX_DATA_BITS))   nbits_c = 4'(MAX_DATA_BITS);
        else                                        nbits_c = i_data_bits;
        tick_c       = (state_q != IDLE) && (tick_cnt_q == div_eff_c - DIV_W'(1));
        bit_done_c   = tick_c && (os_q == 4'd9);
        maj_c        = (s7_q & s8_q) | (s7_q & rx_sync_q) | (s8_q & rx_sync_q);
        start_edge_c = rx_prev_q & ~rx_sync_q;
        par_en_c     = (pmode_q == 2'b01) || (pmode_q == 2'b10);
        last_stop_c  = (stop_cnt_q == stop2_q);
        push_c       = bit_done_c && (state_q == STOP) && last_stop_c;
        brk_c        = zero_q & (stop_cnt_q ? fstop0_q : ~maj_c);
        if (brk_c) begin
            push_entry_c = '{brk: 1'b1, ferr: 1'b1, perr: 1'b0, data: '0};
        end else begin
            push_entry_c = '{brk: 1'b0, ferr: ferr_q | ~maj_c, perr: perr_q, data: data_q};
        end
    end

    // Receive FSM, synchroniser and bit timing
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            tick_cnt_q <= '0;
            os_q       <= '0;
            s7_q       <= 1'b0;
            s8_q       <= 1'b0;
            bit_cnt_q  <= '0;
            nbits_q    <= '0;
            pmode_q    <= '0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
            fstop0_q   <= 1'b0;
            hi_cnt_q   <= '0;
        end else begin
            rx_meta_q <= i_rx_serial;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;

            if (state_q == IDLE) begin
                tick_cnt_q <= '0;
                os_q       <= '0;
                if (start_edge_c) state_q <= START;
            end else if (tick_c) begin
                tick_cnt_q <= '0;
                os_q       <= os_q + 4'd1;
                if (os_q == 4'd7) s7_q <= rx_sync_q;
                if (os_q == 4'd8) s8_q <= rx_sync_q;
            end else begin
                tick_cnt_q <= tick_cnt_q + DIV_W'(1);
            end

            if (bit_done_c) begin
                case (state_q)
                    START: begin
                        if (!maj_c) begin
                            state_q   <= DATA;
                            nbits_q   <= nbits_c;
                            pmode_q   <= i_parity_mode;
                            stop2_q   <= i_stop_bits;
                            data_q    <= '0;
                            bit_cnt_q <= '0;
                            perr_q    <= 1'b0;
                            ferr_q    <= 1'b0;
                            zero_q    <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    DATA: begin
                        for (int i = 0; i < int'(DW); i++) begin
                            if (bit_cnt_q == 4'(i)) data_q[i] <= maj_c;
                        end
                        zero_q    <= zero_q & ~maj_c;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == nbits_q - 4'd1) begin
                            state_q    <= par_en_c ? PARITY : STOP;
                            stop_cnt_q <= 1'b0;
                        end
                    end
                    PARITY: begin
                        perr_q  <= ((^data_q) ^ maj_c) != (pmode_q == 2'b10);
                        zero_q  <= zero_q & ~maj_c;
                        state_q <= STOP;
                    end
                    STOP: begin
                        if (last_stop_c) begin
                            state_q  <= brk_c ? BREAK_WAIT : IDLE;
                            hi_cnt_q <= '0;
                        end else begin
                            stop_cnt_q <= 1'b1;
                            ferr_q     <= ferr_q | ~maj_c;
                            fstop0_q   <= ~maj_c;
                        end
                    end
                    default: ;
                endcase
            end

            // A break is released only by one full bit time of idle line
            if (state_q == BREAK_WAIT) begin
                if (!rx_sync_q) begin
                    hi_cnt_q <= '0;
                end else if (tick_c) begin
                    if (hi_cnt_q == 4'd15) state_q <= IDLE;
                    else                   hi_cnt_q <= hi_cnt_q + 4'd1;
                end
            end
        end
    end

    entry_t           mem_q [FIFO_DEPTH];
    entry_t           head_q, head_d;
    logic [AW-1:0]    rd_q, wr_q, rd_d, wr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, overrun_q;
    logic             pop_c, full_c, push_ok_c, overrun_set_c;

    // FIFO next state; the head register is preloaded so outputs stay registered
    always_comb begin
        pop_c         = valid_q & i_ready;
        full_c        = (count_q == CW'(FIFO_DEPTH));
        push_ok_c     = push_c & (~full_c | pop_c);
        overrun_set_c = push_c & full_c & ~pop_c;
        count_d       = count_q + CW'(push_ok_c) - CW'(pop_c);
        rd_d          = pop_c ? rd_q + AW'(1) : rd_q;
        wr_d          = push_ok_c ? wr_q + AW'(1) : wr_q;
        if (count_d == '0)                 head_d = '0;
        else if (push_ok_c && rd_d == wr_q) head_d = push_entry_c;
        else                               head_d = mem_q[rd_d];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            head_q    <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok_c) mem_q[wr_q] <= push_entry_c;
            head_q  <= head_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
            if (overrun_set_c)    overrun_q <= 1'b1;
            else if (i_clear_err) overrun_q <= 1'b0;
        end
    end

    assign o_data       = head_q.data;
    assign o_parity_err = head_q.perr;
    assign o_frame_err  = head_q.ferr;
    assign o_break      = head_q.brk;
    assign o_valid      = valid_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frame format, errors, break, overrun and reset.
module tb_uart_rx_fifo;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [15:0] div;
    logic [3:0]  nbits;
    logic [1:0]  pmode;
    logic        stop2;
    logic        rdy;
    logic        clr;
    logic [8:0]  o_data;
    logic        o_valid, o_parity_err, o_frame_err, o_break, o_overrun;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    uart_rx_fifo #(.MAX_DATA_BITS(9), .FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clock        (clock),
        .reset        (rst_n),
        .i_rx_serial  (rx),
        .i_baud_div   (div),
        .i_data_bits  (nbits),
        .i_parity_mode(pmode),
        .i_stop_bits  (stop2),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (rdy),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_break      (o_break),
        .o_overrun    (o_overrun),
        .i_clear_err  (clr)
    );

    // Drives one frame; fv is the first posedge (from the start-bit negedge) with o_valid high
    task automatic send_frame(input logic [8:0] val, input int nb, input int pen, input logic pbit,
                              input int ns, input logic s2, input int dv, input int pop_at,
                              output int fv);
        logic [15:0] fb;
        int n;
        int total;
        fb    = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < nb; i++) fb[1+i] = val[i];
        n = 1 + nb;
        if (pen != 0) begin fb[n] = pbit; n++; end
        fb[n] = 1'b1; n++;
        if (ns == 2) begin fb[n] = s2; n++; end
        total = n * 16 * dv;
        fv    = 0;
        @(negedge clock);
        rx  = fb[0];
        rdy = 1'b0;
        for (int k = 1; k <= total; k++) begin
            @(posedge clock); #1;
            if (o_valid && fv == 0) fv = k;
            @(negedge clock);
            rx  = (k < total) ? fb[k/(16*dv)] : 1'b1;
            rdy = (k == pop_at);
        end
    endtask

    task automatic do_pop();
        @(negedge clock); rdy = 1'b1;
        @(negedge clock); rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx = 1'b1; rdy = 1'b0; clr = 1'b0;
        div = 16'd1; nbits = 4'd8; pmode = 2'b00; stop2 = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if (o_data !== 9'h000)  begin failures++; $display("FAIL reset_data got=%h exp=000", o_data); end
        checks++; if (o_parity_err !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", o_parity_err); end
        checks++; if (o_frame_err !== 1'b0)  begin failures++; $display("FAIL reset_ferr got=%b exp=0", o_frame_err); end
        checks++; if (o_break !== 1'b0)   begin failures++; $display("FAIL reset_brk got=%b exp=0", o_break); end
        checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", o_overrun); end
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_clean();
        int fv;
        div = 16'd1; nbits = 4'd8; pmode = 2'b00; stop2 = 1'b0;
        send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1, 0, fv);
        checks++; if (fv !== 157) begin failures++; $display("FAIL clean_latency got=%0d exp=157", fv); end
        checks++; if (o_data !== 9'h0A5) begin failures++; $display("FAIL clean_data got=%h exp=0a5", o_data); end
        checks++; if ({o_break, o_frame_err, o_parity_err} !== 3'b000)
            begin failures++; $display("FAIL clean_flags got=%b exp=000", {o_break, o_frame_err, o_parity_err}); end
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL clean_valid got=%b exp=1", o_valid); end
        do_pop();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL clean_pop got=%b exp=0", o_valid); end
    endtask

    task automatic test_parity();
        int fv;
        div = 16'd3; nbits = 4'd7; pmode = 2'b10; stop2 = 1'b0;
        send_frame(9'h035, 7, 1, 1'b1, 1, 1'b1, 3, 0, fv);
        send_frame(9'h035, 7, 1, 1'b0, 1, 1'b1, 3, 0, fv);
        checks++; if (o_data !== 9'h035) begin failures++; $display("FAIL par_data0 got=%h exp=035", o_data); end
        checks++; if (o_parity_err !== 1'b0) begin failures++; $display("FAIL par_perr0 got=%b exp=0", o_parity_err); end
        checks++; if (o_frame_err !== 1'b0) begin failures++; $display("FAIL par_ferr0 got=%b exp=0", o_frame_err); end
        do_pop();
        checks++; if (o_data !== 9'h035) begin failures++; $display("FAIL par_data1 got=%h exp=035", o_data); end
        checks++; if (o_parity_err !== 1'b1) begin failures++; $display("FAIL par_perr1 got=%b exp=1", o_parity_err); end
        do_pop();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL par_empty got=%b exp=0", o_valid); end
    endtask

    task automatic test_framing();
        int fv;
        div = 16'd1; nbits = 4'd8; pmode = 2'b00; stop2 = 1'b1;
        send_frame(9'h03C, 8, 0, 1'b0, 2, 1'b0, 1, 0, fv);
        checks++; if (o_data !== 9'h03C) begin failures++; $display("FAIL frm_data got=%h exp=03c", o_data); end
        checks++; if (o_frame_err !== 1'b1) begin failures++; $display("FAIL frm_ferr got=%b exp=1", o_frame_err); end
        checks++; if (o_break !== 1'b0) begin failures++; $display("FAIL frm_brk got=%b exp=0", o_break); end
        do_pop();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL frm_empty got=%b exp=0", o_valid); end
        stop2 = 1'b0;
        repeat (20) @(negedge clock);
    endtask

    task automatic test_break();
        int fv;
        div = 16'd1; nbits = 4'd8; pmode = 2'b00; stop2 = 1'b0;
        @(negedge clock); rx = 1'b0;
        repeat (320) @(negedge clock);
        rx = 1'b1;
        repeat (8) @(negedge clock);
        rx = 1'b0;
        repeat (200) @(negedge clock);
        rx = 1'b1;
        repeat (40) @(negedge clock);
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL brk_valid got=%b exp=1", o_valid); end
        checks++; if (o_break !== 1'b1) begin failures++; $display("FAIL brk_flag got=%b exp=1", o_break); end
        checks++; if (o_frame_err !== 1'b1) begin failures++; $display("FAIL brk_ferr got=%b exp=1", o_frame_err); end
        checks++; if (o_data !== 9'h000) begin failures++; $display("FAIL brk_data got=%h exp=000", o_data); end
        do_pop();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL brk_single got=%b exp=0", o_valid); end
        send_frame(9'h05A, 8, 0, 1'b0, 1, 1'b1, 1, 0, fv);
        checks++; if (o_data !== 9'h05A) begin failures++; $display("FAIL brk_next got=%h exp=05a", o_data); end
        checks++; if (o_break !== 1'b0) begin failures++; $display("FAIL brk_next_flag got=%b exp=0", o_break); end
        do_pop();
    endtask

    task automatic test_glitch();
        @(negedge clock); rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (300) @(negedge clock);
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL glitch_push got=%b exp=0", o_valid); end
    endtask

    task automatic test_overrun();
        int fv;
        logic [8:0] exp_d;
        div = 16'd1; nbits = 4'd8; pmode = 2'b00; stop2 = 1'b0;
        for (int i = 1; i <= 4; i++) send_frame(9'(i), 8, 0, 1'b0, 1, 1'b1, 1, 0, fv);
        checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b exp=0", o_overrun); end
        send_frame(9'h005, 8, 0, 1'b0, 1, 1'b1, 1, 0, fv);
        checks++; if (o_overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", o_overrun); end
        for (int i = 1; i <= 4; i++) begin
            exp_d = 9'(i);
            checks++; if (o_data !== exp_d) begin failures++; $display("FAIL ovr_read%0d got=%h exp=%h", i, o_data, exp_d); end
            do_pop();
        end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL ovr_empty got=%b exp=0", o_valid); end
        @(negedge clock); clr = 1'b1;
        @(negedge clock); clr = 1'b0;
        checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", o_overrun); end
    endtask

    task automatic test_back_to_back();
        int fv;
        logic [8:0] exp_d;
        div = 16'd1; nbits = 4'd8; pmode = 2'b00; stop2 = 1'b0;
        for (int i = 1; i <= 4; i++) send_frame(9'(8'h10 + i), 8, 0, 1'b0, 1, 1'b1, 1, 0, fv);
        send_frame(9'h015, 8, 0, 1'b0, 1, 1'b1, 1, 156, fv);
        checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL full_ovr got=%b exp=0", o_overrun); end
        for (int i = 2; i <= 5; i++) begin
            exp_d = 9'(8'h10 + i);
            checks++; if (o_data !== exp_d) begin failures++; $display("FAIL full_read%0d got=%h exp=%h", i, o_data, exp_d); end
            do_pop();
        end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", o_valid); end
    endtask

    task automatic test_reset_mid_frame();
        int fv;
        logic [7:0] pat;
        div = 16'd1; nbits = 4'd8; pmode = 2'b00; stop2 = 1'b0;
        send_frame(9'h021, 8, 0, 1'b0, 1, 1'b1, 1, 0, fv);
        send_frame(9'h022, 8, 0, 1'b0, 1, 1'b1, 1, 0, fv);
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL rmid_queued got=%b exp=1", o_valid); end
        pat = 8'hF3;
        @(negedge clock); rx = 1'b0;
        for (int k = 1; k < 72; k++) begin
            @(negedge clock);
            rx = (k < 16) ? 1'b0 : pat[(k/16)-1];
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", o_valid); end
        checks++; if (o_data !== 9'h000) begin failures++; $display("FAIL rmid_data got=%h exp=000", o_data); end
        rx = 1'b1;
        repeat (4) @(negedge clock);
        rst_n = 1'b1;
        repeat (40) @(negedge clock);
        send_frame(9'h0C3, 8, 0, 1'b0, 1, 1'b1, 1, 0, fv);
        checks++; if (o_data !== 9'h0C3) begin failures++; $display("FAIL rmid_next got=%h exp=0c3", o_data); end
        do_pop();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rmid_empty got=%b exp=0", o_valid); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_parity();
        test_framing();
        test_break();
        test_glitch();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, successor to the fixed-rate 7/8-bit receiver. It recovers serial frames using 16x oversampling with a runtime baud divisor, 3-sample majority voting, and runtime-selectable data length, parity mode and stop-bit count. Received characters and their per-character error flags are buffered in an internal FIFO and presented on a valid/ready interface, with sticky overrun and break reporting. It sits between the pad synchroniser domain and the host register/DMA interface.

Parameters:
MAX_DATA_BITS, 9, widest supported data field; legal range 5..9
FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16
DIV_W, 16, width of the baud divisor input

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, active-low
i_rx_serial  in  1  serial line, asynchronous, idle high
i_baud_div  in  DIV_W  clocks per oversample tick; 0 is treated as 1
i_data_bits  in  4  data bits per frame (5..MAX_DATA_BITS); out-of-range values are clamped to the nearest legal value
i_parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
i_stop_bits  in  1  0 = one stop bit, 1 = two stop bits
o_data  out  MAX_DATA_BITS  FIFO head character, right-aligned, unused MSBs zero
o_valid  out  1  FIFO not empty
i_ready  in  1  consumer accepts head; pop occurs when o_valid && i_ready
o_parity_err  out  1  head entry parity error
o_frame_err  out  1  head entry stop-bit error
o_break  out  1  head entry is a break
o_overrun  out  1  sticky: a frame was dropped because the FIFO was full
i_clear_err  in  1  synchronous pulse; clears o_overrun

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, all counters 0, FIFO empty, synchroniser flops = 1; o_valid=0, o_data=0, all flags=0.
- Input path: 2-flop synchroniser on i_rx_serial. Edge detection and sampling use the synchronised value only.
- Tick generator: counter runs 0..max(i_baud_div,1)-1 and emits a 1-clock tick on wrap. It runs in every state except IDLE. It is restarted at 0 when the start edge is detected.
- Bit timing: 16 ticks per bit. Within each bit, samples are taken at ticks 7, 8 and 9; the bit value is the 2-of-3 majority, decided at tick 9.
- Configuration (i_data_bits, i_parity_mode, i_stop_bits) is latched on start-bit qualification. Changes mid-frame have no effect until the next frame.
- FSM states and transitions:
  - IDLE: a synchronised high-to-low transition goes to START.
  - START: at tick 9, majority 0 goes to DATA; majority 1 is a false start and returns to IDLE, with nothing pushed.
  - DATA: receives data bits LSB first. After the latched count, goes to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: samples one bit. Parity error if XOR(data, parity bit) is not 0 for even mode, or not 1 for odd mode.
  - STOP: samples 1 or 2 stop bits. Frame error if any stop sample is 0. The push happens at tick 9 of the last stop bit, and the FSM goes to IDLE the next clock, giving half-bit slack for the next start edge.
  - BREAK_WAIT: entered after the push when the frame is a break. Returns to IDLE only once the synchronised line has been 1 for one full bit (16 ticks).
- Break: all data bits 0, parity bit (if enabled) 0, and first stop bit 0. The entry is pushed with o_break=1, o_frame_err=1 and data 0.
- FIFO entry: {break, frame_err, parity_err, data}. Outputs are driven from the head, registered, with no combinational path from i_ready to o_valid.
- Latency: if the FIFO is empty, o_valid rises 1 clock after the push clock.
- Full FIFO:
  - A push with no simultaneous pop is dropped, sets o_overrun, and leaves the existing entries intact.
  - A push and pop in the same clock while full succeeds with no overrun.
  - Pop while empty is ignored.
- i_clear_err and an overrun event in the same clock: o_overrun stays set (set wins).
- Reset mid-frame discards the partial frame and all FIFO contents.

Test Plan:
- Clean frame: div=1, 8N1, send 0xA5 -> exactly one push; o_data=0x0A5 with o_valid 1 clock after the push; all flags 0; i_ready=1 pops and o_valid drops the next clock.
- Parity and length: div=3, 7 data bits, odd parity, send 0x35 with a correct parity bit, then 0x35 with the parity bit flipped -> entries 0x035 with perr=0, then 0x035 with perr=1; data bit 7 is zero.
- Framing, break and false start:
  - 8N2, second stop bit 0 -> ferr=1.
  - Line held low for 2 frame times -> one entry with brk=1, ferr=1, data 0, and no further pushes until the line is high for 16 ticks.
  - 4-tick low glitch -> no push.
- Overrun: FIFO_DEPTH=4, i_ready=0, send 5 frames 0x01..0x05 -> the 5th is dropped, o_overrun=1, and reads return 0x01..0x04. i_clear_err clears o_overrun.
- Full boundary: with the FIFO full, assert i_ready on the same clock as the 5th push -> no overrun, and order is preserved.
- Reset mid-frame: assert reset during DATA bit 3 with 2 entries queued -> o_valid=0 immediately; the next clean frame is received correctly.
